hisep_cctrl_core: RTL and testbench
===================================

Name: hisep_cctrl_core

Overview:
- 64-bit classical control processor for the HiSEP-Q controller.
- Fetches 64-bit instructions from an external program RAM (PRAM) and executes classical ALU, load/store, compare and branch operations against an external data RAM (DRAM).
- Forwards quantum instructions, with decoded strobes, to the quantum timing/issue back-end.
- Sits between the host start/end handshake, the PRAM/DRAM macros and the quantum pipeline.

Parameters:
- NREG, 32, number of 64-bit general registers (R0 reads as 0).
- PADDR_W, 11, PRAM address width.
- DADDR_W, 11, DRAM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start_sig  in  64  bit0=1 enables execution; other bits reserved.
- end_sig  out  64  bit0 set on STOP, held until reset; others 0.
- i_q_measurement  in  64  qubit measurement vector.
- pram_en/pram_rd_en  out  1  PRAM enable/read.
- pram_addr  out  11  fetch address = current PC.
- instruction  in  64  PRAM data (valid one cycle after address).
- dram_en/dram_rd_en/dram_wr_en  out  1  DRAM enable/read/write.
- dram_addr  out  11  load/store address.
- dram_din  out  64  store data.
- data_read  in  64  load data (same cycle, DRAM clocked on inverted_clk).
- inverted_clk  out  1  ~clk for DRAM.
- q_inst  out  64  instruction word forwarded to quantum side.
- q_vliw, q_slm, q_rot, q_time_write, q_time_sel  out  1  quantum strobes.
- q_reg_write  out  2  quantum register-write strobes.
- q_time_reg  out  64  timing value for QWAIT.
- meas_rd_addr  out  5  selected measurement bit for FMR.

Behaviour:
- Encoding: opcode [62:56], bit63=0. Fields: rd [55:51], rs [50:46], rt [45:41], imm [40:0] (zero-extended). Branch fields: cond [55:52], offset [19:0] (signed).
- Opcodes:
  - 00 NOP; 01 BR cond,off; 02 JUMP off; 03 LDI rd,imm; 04 LD rd,imm(rs); 05 ST rt,imm(rs); 06 CMP rs,rt; 07 ADD; 08 SUB; 09 AND; 0A OR; 0B XOR (rd=rs op rt); 0C FMR rd,imm[4:0]; 0D STOP.
  - Quantum: 40 SMSOL (2 words), 41 SITO, 42 QWAIT imm, 43 ROT.
  - Undefined opcodes: NOP.
- Reset: PC=0, regs=0, flags=0, end_sig=0. All strobes, dram_* and pram_* are 0; q_inst=0, q_time_reg=0.
- While start_sig[0]=0: PC holds, pram_en=0.
- Pipeline: 2 stages, fetch then execute. pram_addr=PC; the word returned next cycle executes while PC=addr+1. Register/flag writes land at the end of that execute cycle.
- Arithmetic: 64-bit wrap-around; no exceptions.
- CMP flags: EQ, NE, LT (signed), GT.
- BR cond codes: 0 always, 1 EQ, 2 NE, 3 LT, 4 GT, 5 GE, 6 LE.
- Branch/jump target = branch address + offset. A taken branch squashes the already-fetched next word (1-cycle bubble). Example: BR NE +2 at address 9 goes to 11, and 10 never executes.
- LD: dram_en=dram_rd_en=1, dram_addr=(rs+imm)[10:0]; rd<=data_read in the same execute cycle.
- ST: dram_en=dram_wr_en=1, dram_din=rt.
- FMR: meas_rd_addr=imm[4:0]; rd<={63'b0, i_q_measurement[meas_rd_addr]}.
- Quantum ops: no GPR write; q_inst=word, combinational during execute.
  - SMSOL: q_vliw=1, q_reg_write[0]=1. Next word is payload, forwarded on q_inst with strobes 0 and no classical decode.
  - SITO: q_reg_write[1]=1.
  - QWAIT: q_time_write=1, q_time_sel=0, q_time_reg=imm.
  - ROT: q_rot=1; q_slm=1 if word bit[40] set.
- STOP: end_sig[0]=1; PC freezes.
- Write to R0 is discarded.
- Reset mid-execution aborts immediately to reset state.

Decomposition:
- Package hisep_cctrl_pkg: opcode enum, field-slice constants, cond-code enum, flag struct.
- Sub-modules:
  - hisep_regfile: 32x64, 2 read ports, 1 write port.
  - PC generator kept inline.

Test Plan:
- DRAM[x]=524296; program LDI R10,10; LDI R8,8; LDI R4,4; LD R3 -> R10=10, R8=8, R4=4, R3=524296 one cycle after each fetch.
- ST R10 to addr 12 -> DRAM[12]=10.
- CMP R0,R3; BR EQ +2 at 8; BR NE +2 at 9 -> no jump at 8, PC 9->11, FMR at 10 skipped.
- ADD R10,R8,R4 -> R10=12.
- SMSOL+payload, SITO, QWAIT 15, ROT:
  - SMSOL: q_vliw=1, q_reg_write[0]=1.
  - Payload: reg_write=0.
  - SITO: q_reg_write[1]=1.
  - QWAIT: q_time_write=1, q_time_reg=15.
  - ROT: q_rot=1.
  - GPRs unchanged throughout (R18=0, R4=4).
- FMR R5,bit0 with i_q_measurement=DEADBEEF -> R5=1. STOP -> end_sig=1, PC frozen. Assert rst low mid-run -> all outputs 0, PC=0.

Source files
------------

// File: rtl/hisep_cctrl_pkg.sv
// Shared encoding definitions for the HiSEP-Q classical control core:
// opcodes, instruction field positions, branch conditions and compare flags.
package hisep_cctrl_pkg;

    typedef enum logic [6:0] {
        OP_NOP   = 7'h00,
        OP_BR    = 7'h01,
        OP_JUMP  = 7'h02,
        OP_LDI   = 7'h03,
        OP_LD    = 7'h04,
        OP_ST    = 7'h05,
        OP_CMP   = 7'h06,
        OP_ADD   = 7'h07,
        OP_SUB   = 7'h08,
        OP_AND   = 7'h09,
        OP_OR    = 7'h0A,
        OP_XOR   = 7'h0B,
        OP_FMR   = 7'h0C,
        OP_STOP  = 7'h0D,
        OP_SMSOL = 7'h40,
        OP_SITO  = 7'h41,
        OP_QWAIT = 7'h42,
        OP_ROT   = 7'h43
    } opcode_e;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_LT = 4'd3,
        COND_GT = 4'd4,
        COND_GE = 4'd5,
        COND_LE = 4'd6
    } cond_e;

    typedef struct packed {
        logic eq;
        logic ne;
        logic lt;
        logic gt;
    } flags_t;

    localparam int OP_MSB   = 62;
    localparam int OP_LSB   = 56;
    localparam int RD_LSB   = 51;
    localparam int RS_LSB   = 46;
    localparam int RT_LSB   = 41;
    localparam int IMM_MSB  = 40;
    localparam int COND_MSB = 55;
    localparam int COND_LSB = 52;
    localparam int SLM_BIT  = 40;

    function automatic logic cond_met(input logic [3:0] cond, input flags_t f);
        case (cond_e'(cond))
            COND_AL: return 1'b1;
            COND_EQ: return f.eq;
            COND_NE: return f.ne;
            COND_LT: return f.lt;
            COND_GT: return f.gt;
            COND_GE: return f.gt | f.eq;
            COND_LE: return f.lt | f.eq;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hisep_regfile.sv
// General register file: two combinational read ports, one synchronous write
// port; R0 is hard-wired to zero.
module hisep_regfile #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [63:0]   wd,
    output logic [63:0]   rd1,
    output logic [63:0]   rd2
);

    logic [63:0] regs [NREG];

    // NOTE: the array is reset because the architecture guarantees all-zero
    // registers after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/hisep_cctrl_core.sv
// Two-stage (fetch/execute) classical control core that runs classical ops
// against PRAM/DRAM and forwards quantum instructions with decoded strobes.
module hisep_cctrl_core
    import hisep_cctrl_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int PADDR_W = 11,
    parameter int DADDR_W = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        start_sig,
    output logic [63:0]        end_sig,
    input  logic [63:0]        i_q_measurement,
    output logic               pram_en,
    output logic               pram_rd_en,
    output logic [PADDR_W-1:0] pram_addr,
    input  logic [63:0]        instruction,
    output logic               dram_en,
    output logic               dram_rd_en,
    output logic               dram_wr_en,
    output logic [DADDR_W-1:0] dram_addr,
    output logic [63:0]        dram_din,
    input  logic [63:0]        data_read,
    output logic               inverted_clk,
    output logic [63:0]        q_inst,
    output logic               q_vliw,
    output logic               q_slm,
    output logic               q_rot,
    output logic               q_time_write,
    output logic               q_time_sel,
    output logic [1:0]         q_reg_write,
    output logic [63:0]        q_time_reg,
    output logic [4:0]         meas_rd_addr
);

    localparam int RAW = $clog2(NREG);
    localparam logic [PADDR_W-1:0] PC_ONE = PADDR_W'(1);

    logic [PADDR_W-1:0] pc;
    logic [PADDR_W-1:0] ex_pc;
    logic               ex_valid;
    logic               payload_pending;
    logic               halted;
    logic               active;
    flags_t             flags;
    flags_t             cmp_flags;

    opcode_e            op;
    logic [63:0]        rs_val;
    logic [63:0]        rt_val;
    logic [63:0]        imm;
    logic [PADDR_W-1:0] br_target;
    logic               rf_we;
    logic [63:0]        rf_wd;
    logic               flags_we;
    logic               branch_taken;
    logic               stop_exec;
    logic               unused_bits;

    assign unused_bits  = &{1'b0, start_sig[63:1]};
    assign inverted_clk = ~clk;
    assign end_sig      = {63'b0, halted};

    assign pram_en    = active & start_sig[0] & ~halted;
    assign pram_rd_en = pram_en;
    assign pram_addr  = pc;

    // The payload word after SMSOL is never decoded as a classical op.
    assign op  = (ex_valid && !payload_pending && !instruction[63])
               ? opcode_e'(instruction[OP_MSB:OP_LSB]) : OP_NOP;
    assign imm = {{(63 - IMM_MSB){1'b0}}, instruction[IMM_MSB:0]};

    // The 20-bit signed offset wraps identically when truncated to PC width.
    assign br_target = ex_pc + instruction[PADDR_W-1:0];

    assign cmp_flags.eq = (rs_val == rt_val);
    assign cmp_flags.ne = (rs_val != rt_val);
    assign cmp_flags.lt = ($signed(rs_val) < $signed(rt_val));
    assign cmp_flags.gt = ($signed(rs_val) > $signed(rt_val));

    hisep_regfile #(.NREG(NREG), .AW(RAW)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (instruction[RS_LSB +: RAW]),
        .ra2 (instruction[RT_LSB +: RAW]),
        .we  (rf_we),
        .wa  (instruction[RD_LSB +: RAW]),
        .wd  (rf_wd),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned (no latches).
    always_comb begin
        rf_we        = 1'b0;
        rf_wd        = '0;
        flags_we     = 1'b0;
        branch_taken = 1'b0;
        stop_exec    = 1'b0;
        dram_en      = 1'b0;
        dram_rd_en   = 1'b0;
        dram_wr_en   = 1'b0;
        dram_addr    = '0;
        dram_din     = '0;
        q_inst       = '0;
        q_vliw       = 1'b0;
        q_slm        = 1'b0;
        q_rot        = 1'b0;
        q_time_write = 1'b0;
        q_time_sel   = 1'b0;
        q_reg_write  = 2'b00;
        q_time_reg   = '0;
        meas_rd_addr = '0;

        case (op)
            OP_BR:   branch_taken = cond_met(instruction[COND_MSB:COND_LSB], flags);
            OP_JUMP: branch_taken = 1'b1;
            OP_LDI: begin
                rf_we = 1'b1;
                rf_wd = imm;
            end
            OP_LD: begin
                dram_en    = 1'b1;
                dram_rd_en = 1'b1;
                dram_addr  = rs_val[DADDR_W-1:0] + instruction[DADDR_W-1:0];
                rf_we      = 1'b1;
                rf_wd      = data_read;
            end
            OP_ST: begin
                dram_en    = 1'b1;
                dram_wr_en = 1'b1;
                dram_addr  = rs_val[DADDR_W-1:0] + instruction[DADDR_W-1:0];
                dram_din   = rt_val;
            end
            OP_CMP: flags_we = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                rf_we = 1'b1;
                case (op)
                    OP_ADD:  rf_wd = rs_val + rt_val;
                    OP_SUB:  rf_wd = rs_val - rt_val;
                    OP_AND:  rf_wd = rs_val & rt_val;
                    OP_OR:   rf_wd = rs_val | rt_val;
                    default: rf_wd = rs_val ^ rt_val;
                endcase
            end
            OP_FMR: begin
                meas_rd_addr = instruction[4:0];
                rf_we        = 1'b1;
                rf_wd        = {63'b0, i_q_measurement[{1'b0, instruction[4:0]}]};
            end
            OP_STOP: stop_exec = 1'b1;
            OP_SMSOL: begin
                q_inst      = instruction;
                q_vliw      = 1'b1;
                q_reg_write = 2'b01;
            end
            OP_SITO: begin
                q_inst      = instruction;
                q_reg_write = 2'b10;
            end
            OP_QWAIT: begin
                q_inst       = instruction;
                q_time_write = 1'b1;
                q_time_reg   = imm;
            end
            OP_ROT: begin
                q_inst = instruction;
                q_rot  = 1'b1;
                q_slm  = instruction[SLM_BIT];
            end
            default: ;
        endcase

        if (ex_valid && payload_pending) q_inst = instruction;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc              <= '0;
            ex_pc           <= '0;
            ex_valid        <= 1'b0;
            payload_pending <= 1'b0;
            halted          <= 1'b0;
            active          <= 1'b0;
            flags           <= '0;
        end else begin
            active <= 1'b1;
            if (flags_we) flags <= cmp_flags;
            if (ex_valid) payload_pending <= (op == OP_SMSOL);

            // A taken branch or STOP discards the word fetched alongside it.
            if (stop_exec) begin
                halted   <= 1'b1;
                ex_valid <= 1'b0;
            end else if (branch_taken) begin
                pc       <= br_target;
                ex_valid <= 1'b0;
            end else if (pram_en) begin
                pc       <= pc + PC_ONE;
                ex_pc    <= pc;
                ex_valid <= 1'b1;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hisep_cctrl_core.sv
// Directed bench: runs a small program from a modelled PRAM/DRAM and checks
// register, memory and strobe results against hand-computed values.
module tb_hisep_cctrl_core;
    import hisep_cctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] start_sig = '0;
    logic [63:0] end_sig;
    logic [63:0] i_q_measurement = 64'hDEADBEEF;
    logic        pram_en, pram_rd_en;
    logic [10:0] pram_addr;
    logic [63:0] instruction = '0;
    logic        dram_en, dram_rd_en, dram_wr_en;
    logic [10:0] dram_addr;
    logic [63:0] dram_din;
    logic [63:0] data_read;
    logic        inverted_clk;
    logic [63:0] q_inst;
    logic        q_vliw, q_slm, q_rot, q_time_write, q_time_sel;
    logic [1:0]  q_reg_write;
    logic [63:0] q_time_reg;
    logic [4:0]  meas_rd_addr;

    logic [63:0] pram [2048];
    logic [63:0] dram [2048];

    int n_checks = 0;
    int n_fail   = 0;

    hisep_cctrl_core dut (
        .clk             (clk),
        .rst             (rst),
        .start_sig       (start_sig),
        .end_sig         (end_sig),
        .i_q_measurement (i_q_measurement),
        .pram_en         (pram_en),
        .pram_rd_en      (pram_rd_en),
        .pram_addr       (pram_addr),
        .instruction     (instruction),
        .dram_en         (dram_en),
        .dram_rd_en      (dram_rd_en),
        .dram_wr_en      (dram_wr_en),
        .dram_addr       (dram_addr),
        .dram_din        (dram_din),
        .data_read       (data_read),
        .inverted_clk    (inverted_clk),
        .q_inst          (q_inst),
        .q_vliw          (q_vliw),
        .q_slm           (q_slm),
        .q_rot           (q_rot),
        .q_time_write    (q_time_write),
        .q_time_sel      (q_time_sel),
        .q_reg_write     (q_reg_write),
        .q_time_reg      (q_time_reg),
        .meas_rd_addr    (meas_rd_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (pram_en) instruction <= pram[pram_addr];
    always @(negedge clk) if (dram_en && dram_wr_en) dram[dram_addr] <= dram_din;
    assign data_read = dram[dram_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [40:0] imm);
        return {1'b0, op, rd, rs, rt, imm};
    endfunction

    function automatic logic [63:0] enc_br(input logic [6:0] op, input logic [3:0] cond,
                                           input logic [19:0] off);
        return {1'b0, op, cond, 32'b0, off};
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) begin
            pram[i] = '0;
            dram[i] = '0;
        end
        dram[20] = 64'd524296;

        pram[0]  = enc(OP_LDI, 5'd10, 5'd0, 5'd0, 41'd10);
        pram[1]  = enc(OP_LDI, 5'd8,  5'd0, 5'd0, 41'd8);
        pram[2]  = enc(OP_LDI, 5'd4,  5'd0, 5'd0, 41'd4);
        pram[3]  = enc(OP_LD,  5'd3,  5'd0, 5'd0, 41'd20);
        pram[4]  = enc(OP_ST,  5'd0,  5'd0, 5'd10, 41'd12);
        pram[5]  = enc(OP_CMP, 5'd0,  5'd0, 5'd3, 41'd0);
        pram[8]  = enc_br(OP_BR, 4'd1, 20'd2);
        pram[9]  = enc_br(OP_BR, 4'd2, 20'd2);
        pram[10] = enc(OP_FMR, 5'd6,  5'd0, 5'd0, 41'd0);
        pram[11] = enc(OP_ADD, 5'd10, 5'd8, 5'd4, 41'd0);
        pram[12] = enc(OP_SMSOL, 5'd0, 5'd0, 5'd0, 41'h123);
        pram[13] = enc(OP_LDI, 5'd18, 5'd0, 5'd0, 41'h55);
        pram[14] = enc(OP_SITO, 5'd0, 5'd0, 5'd0, 41'd1);
        pram[15] = enc(OP_QWAIT, 5'd0, 5'd0, 5'd0, 41'd15);
        pram[16] = enc(OP_ROT, 5'd0, 5'd0, 5'd0, 41'd1 << 40);
        pram[17] = enc(OP_FMR, 5'd5,  5'd0, 5'd0, 41'd0);
        pram[18] = enc(OP_SUB, 5'd7,  5'd8, 5'd10, 41'd0);
        pram[19] = enc(OP_ST,  5'd0,  5'd0, 5'd7, 41'd14);
        pram[20] = enc_br(OP_JUMP, 4'd0, 20'd2);
        pram[21] = enc(OP_LDI, 5'd9,  5'd0, 5'd0, 41'd99);
        pram[22] = enc(OP_STOP, 5'd0, 5'd0, 5'd0, 41'd0);
        pram[23] = enc(OP_LDI, 5'd9,  5'd0, 5'd0, 41'd77);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pram_en", {63'b0, pram_en}, 64'd0);
        check("rst_pram_addr", {53'b0, pram_addr}, 64'd0);
        check("rst_end_sig", end_sig, 64'd0);
        check("rst_q_inst", q_inst, 64'd0);
        check("rst_dram_en", {63'b0, dram_en}, 64'd0);
        rst = 1'b1;
        tick();
        check("idle_pram_en", {63'b0, pram_en}, 64'd0);
        check("idle_pc_hold", {53'b0, pram_addr}, 64'd0);
        start_sig = 64'd1;
        #1;
        check("start_pram_en", {63'b0, pram_en}, 64'd1);

        tick();                                    // exec 0
        tick();                                    // exec 1
        check("r10_ldi", dut.u_regfile.regs[10], 64'd10);
        tick();                                    // exec 2
        check("r8_ldi", dut.u_regfile.regs[8], 64'd8);
        tick();                                    // exec 3: LD
        check("ld_strobe", {62'b0, dram_en, dram_rd_en}, 64'd3);
        check("ld_addr", {53'b0, dram_addr}, 64'd20);
        check("r4_ldi", dut.u_regfile.regs[4], 64'd4);
        tick();                                    // exec 4: ST
        check("r3_ld", dut.u_regfile.regs[3], 64'd524296);
        check("st_wr_en", {63'b0, dram_wr_en}, 64'd1);
        check("st_din", dram_din, 64'd10);
        tick();                                    // exec 5: CMP
        check("dram12", dram[12], 64'd10);
        tick();
        tick();
        tick();                                    // exec 8: BR EQ not taken
        check("br_eq_fallthru", {53'b0, pram_addr}, 64'd9);
        tick();                                    // exec 9: BR NE taken
        check("br_ne_fetch10", {53'b0, pram_addr}, 64'd10);
        tick();                                    // bubble
        check("br_target_pc", {53'b0, pram_addr}, 64'd11);
        check("bubble_q_inst", q_inst, 64'd0);
        tick();                                    // exec 11: ADD
        tick();                                    // exec 12: SMSOL
        check("add_r10", dut.u_regfile.regs[10], 64'd12);
        check("fmr_skipped_r6", dut.u_regfile.regs[6], 64'd0);
        check("smsol_vliw", {63'b0, q_vliw}, 64'd1);
        check("smsol_reg_write", {62'b0, q_reg_write}, 64'd1);
        check("smsol_q_inst", q_inst, pram[12]);
        tick();                                    // exec 13: payload
        check("payload_q_inst", q_inst, pram[13]);
        check("payload_strobes", {61'b0, q_vliw, q_reg_write}, 64'd0);
        tick();                                    // exec 14: SITO
        check("sito_reg_write", {62'b0, q_reg_write}, 64'd2);
        check("payload_no_gpr", dut.u_regfile.regs[18], 64'd0);
        tick();                                    // exec 15: QWAIT
        check("qwait_strobe", {62'b0, q_time_write, q_time_sel}, 64'd2);
        check("qwait_time_reg", q_time_reg, 64'd15);
        tick();                                    // exec 16: ROT
        check("rot_strobes", {62'b0, q_rot, q_slm}, 64'd3);
        tick();                                    // exec 17: FMR
        check("fmr_meas_addr", {59'b0, meas_rd_addr}, 64'd0);
        check("r4_unchanged", dut.u_regfile.regs[4], 64'd4);
        tick();                                    // exec 18: SUB
        check("fmr_r5", dut.u_regfile.regs[5], 64'd1);
        tick();                                    // exec 19: ST
        check("sub_din", dram_din, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();                                    // exec 20: JUMP
        tick();                                    // bubble
        check("jump_target", {53'b0, pram_addr}, 64'd22);
        check("dram14", dram[14], 64'hFFFF_FFFF_FFFF_FFFC);
        tick();                                    // exec 22: STOP
        check("stop_end_pending", end_sig, 64'd0);
        tick();
        check("stop_end_sig", end_sig, 64'd1);
        check("stop_pram_en", {63'b0, pram_en}, 64'd0);
        tick();
        tick();
        check("stop_pc_frozen", {53'b0, pram_addr}, 64'd23);
        check("stop_end_held", end_sig, 64'd1);
        check("squashed_r9", dut.u_regfile.regs[9], 64'd0);

        // Restart after reset, then reset asynchronously mid-run
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        tick();                                    // exec 0
        tick();                                    // exec 1
        check("restart_r10", dut.u_regfile.regs[10], 64'd10);
        tick();                                    // exec 2
        #2;
        rst = 1'b0;
        #1;
        check("midrst_pram_en", {63'b0, pram_en}, 64'd0);
        check("midrst_pc", {53'b0, pram_addr}, 64'd0);
        check("midrst_r10", dut.u_regfile.regs[10], 64'd0);
        check("midrst_end_sig", end_sig, 64'd0);
        check("midrst_q_inst", q_inst, 64'd0);
        check("midrst_dram", {61'b0, dram_en, dram_rd_en, dram_wr_en}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
